// File: rtl/image_proc_pkg.sv
// Shared types for the image capture pipeline: capture FSM states, the
// per-pixel marker flags and the frame-decimation keep rule.
package image_proc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACTIVE = 2'd2,
        DROP   = 2'd3
    } cap_state_t;

    typedef struct packed {
        logic sof;
        logic eol;
    } cap_flags_t;

    localparam int FLAG_W = $bits(cap_flags_t);

    // A frame is kept when the low n bits of its index are zero (1 of 2^n).
    // The index is 3 bits wide so it wraps cleanly for every mask up to 7.
    function automatic logic keep_frame(input logic [2:0] idx, input logic [1:0] n);
        logic [2:0] mask;
        mask = 3'((4'd1 << n) - 4'd1);
        return (idx & mask) == 3'd0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head word is visible while
// valid is high; a pop happens on any cycle with valid && pop_ready. A push
// into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop;
    logic             accept;

    assign valid  = (wr_ptr != rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop    = valid && pop_ready;
    assign accept = push && (!full || pop);
    // Gate the head so the output reads zero whenever the FIFO is empty.
    assign head   = valid ? mem[rd_ptr[AW-1:0]] : '0;

    // Read/write pointers, one extra bit to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)    rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cam_stream_capture.sv
// DVP camera capture front-end: assembles bytes into pixels, tags frame and
// line boundaries, checks line/frame lengths, decimates frames and buffers
// pixels in an output FIFO.
// Output handshake: o_pixel/o_sof/o_eol are meaningful only while o_valid is
// high and hold steady until the cycle where o_valid && i_ready, which is the
// transfer; o_valid never depends on i_ready.
module cam_stream_capture
    import image_proc_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BPP        = 2,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_byte_en,
    input  logic [DATA_W-1:0]     i_data,
    input  logic                  i_hsync,
    input  logic                  i_vsync,
    input  logic                  i_enable,
    input  logic [1:0]            i_decimate,
    input  logic                  i_swap_bytes,
    input  logic                  i_clear_status,
    output logic [DATA_W*BPP-1:0] o_pixel,
    output logic                  o_sof,
    output logic                  o_eol,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_line_err,
    output logic                  o_frame_err,
    output logic                  o_overflow,
    output logic [15:0]           o_frame_cnt,
    output cap_state_t            o_state
);

    localparam int PIX_W      = DATA_W * BPP;
    localparam int ENT_W      = FLAG_W + PIX_W;
    localparam int LINE_BYTES = H_ACTIVE * BPP;
    // Counters carry one spare bit and saturate, so overlong lines and
    // frames never wrap back onto the nominal value.
    localparam int BC_W = $clog2(LINE_BYTES + 1) + 1;
    localparam int PX_W = $clog2(H_ACTIVE + 1) + 1;
    localparam int LN_W = $clog2(V_ACTIVE + 2) + 1;
    localparam int BI_W = (BPP > 1) ? $clog2(BPP) : 1;

    cap_state_t                    state;
    logic                          hsync_q;
    logic                          vsync_q;
    logic [2:0]                    frame_idx;
    logic [BI_W-1:0]               byte_idx;
    logic [BC_W-1:0]               line_bytes;
    logic [PX_W-1:0]               pix_idx;
    logic [LN_W-1:0]               line_cnt;
    logic [BPP-1:0][DATA_W-1:0]    asm_bytes;
    logic                          wr_pend;
    cap_flags_t                    wr_flags;
    logic [PIX_W-1:0]              pixel_asm;
    logic [ENT_W-1:0]              fifo_head;
    logic                          fifo_full;

    logic hs_fall;
    logic vs_fall;
    logic vs_rise;
    logic take;
    logic last_byte;

    assign hs_fall   = hsync_q && !i_hsync;
    assign vs_fall   = vsync_q && !i_vsync;
    assign vs_rise   = !vsync_q && i_vsync;
    assign take      = (state == ACTIVE) && i_byte_en && i_hsync;
    assign last_byte = (byte_idx == BI_W'(BPP - 1));

    // Registered copies of the sync lines for edge detection.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            hsync_q <= i_hsync;
            vsync_q <= i_vsync;
        end
    end

    // Capture FSM with byte/pixel/line counters and the error pulses.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            frame_idx   <= '0;
            byte_idx    <= '0;
            line_bytes  <= '0;
            pix_idx     <= '0;
            line_cnt    <= '0;
            asm_bytes   <= '0;
            wr_pend     <= 1'b0;
            wr_flags    <= '0;
            o_line_err  <= 1'b0;
            o_frame_err <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            o_line_err  <= 1'b0;
            o_frame_err <= 1'b0;
            wr_pend     <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_enable) state <= WAIT;
                end
                WAIT: begin
                    if (vs_fall) begin
                        frame_idx  <= frame_idx + 3'd1;
                        byte_idx   <= '0;
                        line_bytes <= '0;
                        pix_idx    <= '0;
                        line_cnt   <= '0;
                        state      <= keep_frame(frame_idx, i_decimate) ? ACTIVE : DROP;
                    end
                end
                ACTIVE: begin
                    if (vs_rise) begin
                        if (line_cnt != LN_W'(V_ACTIVE)) o_frame_err <= 1'b1;
                        else                             o_frame_cnt <= o_frame_cnt + 16'd1;
                        state <= i_enable ? WAIT : IDLE;
                    end else if (hs_fall) begin
                        o_line_err <= (line_bytes != BC_W'(LINE_BYTES));
                        byte_idx   <= '0;
                        line_bytes <= '0;
                        pix_idx    <= '0;
                        if (line_cnt != LN_W'(V_ACTIVE + 1)) line_cnt <= line_cnt + LN_W'(1);
                    end else if (take) begin
                        asm_bytes[byte_idx] <= i_data;
                        if (line_bytes != '1) line_bytes <= line_bytes + BC_W'(1);
                        if (last_byte) begin
                            byte_idx <= '0;
                            if (pix_idx != PX_W'(H_ACTIVE)) pix_idx <= pix_idx + PX_W'(1);
                            if (pix_idx < PX_W'(H_ACTIVE) && line_cnt < LN_W'(V_ACTIVE)) wr_pend <= 1'b1;
                            wr_flags.sof <= (line_cnt == '0) && (pix_idx == '0);
                            wr_flags.eol <= (pix_idx == PX_W'(H_ACTIVE - 1));
                        end else begin
                            byte_idx <= byte_idx + BI_W'(1);
                        end
                    end
                end
                DROP: begin
                    if (vs_rise) state <= i_enable ? WAIT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte order into the pixel: first byte lands in the MSB unless swapped.
    always_comb begin
        pixel_asm = '0;
        for (int k = 0; k < BPP; k++) begin
            if (i_swap_bytes) pixel_asm[k*DATA_W +: DATA_W]         = asm_bytes[k];
            else              pixel_asm[(BPP-1-k)*DATA_W +: DATA_W] = asm_bytes[k];
        end
    end

    // Sticky overflow: a push into a full FIFO with no pop drops the pixel.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)                                          o_overflow <= 1'b0;
        else if (wr_pend && fifo_full && !(o_valid && i_ready))  o_overflow <= 1'b1;
        else if (i_clear_status)                                 o_overflow <= 1'b0;
    end

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_reset_n),
        .push      (wr_pend),
        .push_data ({wr_flags, pixel_asm}),
        .pop_ready (i_ready),
        .head      (fifo_head),
        .valid     (o_valid),
        .full      (fifo_full)
    );

    assign {o_sof, o_eol, o_pixel} = fifo_head;
    assign o_state = state;

endmodule

// File: tb/tb_cam_stream_capture.sv
// Bench for cam_stream_capture: table of whole-frame scenarios, hand-written
// overflow / decimation / mid-line reset sequences, then randomized frames,
// all checked against a frame-level reference model and an expected queue.
module tb_cam_stream_capture;
    import image_proc_pkg::*;

    localparam int DATA_W = 8, BPP = 2, H_ACTIVE = 4, V_ACTIVE = 2, FIFO_DEPTH = 4;

    logic        clk;
    logic        i_reset_n, i_byte_en, i_hsync, i_vsync, i_enable;
    logic [7:0]  i_data;
    logic [1:0]  i_decimate;
    logic        i_swap_bytes, i_clear_status, i_ready;
    logic [15:0] o_pixel;
    logic        o_sof, o_eol, o_valid, o_line_err, o_frame_err, o_overflow;
    logic [15:0] o_frame_cnt;
    cap_state_t  o_state;

    cam_stream_capture #(
        .DATA_W(DATA_W), .BPP(BPP), .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_byte_en(i_byte_en), .i_data(i_data),
        .i_hsync(i_hsync), .i_vsync(i_vsync), .i_enable(i_enable),
        .i_decimate(i_decimate), .i_swap_bytes(i_swap_bytes),
        .i_clear_status(i_clear_status), .o_pixel(o_pixel), .o_sof(o_sof),
        .o_eol(o_eol), .o_valid(o_valid), .i_ready(i_ready),
        .o_line_err(o_line_err), .o_frame_err(o_frame_err),
        .o_overflow(o_overflow), .o_frame_cnt(o_frame_cnt), .o_state(o_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic        swap;
        int          nlines;
        int          len0, len1, len2;
        int          exp_pix;
        int          exp_lerr;
        logic        exp_ferr;
        logic [15:0] exp_first;
    } vec_t;

    vec_t        vecs[7];
    int          tests, fails;
    logic [17:0] exp_q[$];
    int          pops;
    logic [15:0] first_pix;
    int          got_lerr;
    logic        got_ferr;
    int          m_frame_idx, m_frame_cnt;
    logic        cfg_swap;
    logic [1:0]  cfg_dec;
    int          n_lines;
    int          line_len[4];
    logic [7:0]  fb[64];
    bit          rand_ready, par;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard: every accepted head word must match the queue front.
    task automatic monitor_sample();
        logic [17:0] e;
        if (o_valid && i_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got %0h expected nothing", {o_sof, o_eol, o_pixel});
            end else begin
                e = exp_q.pop_front();
                if ({o_sof, o_eol, o_pixel} !== e) begin
                    fails++;
                    $display("FAIL pixel: got %0h expected %0h", {o_sof, o_eol, o_pixel}, e);
                end
                if (pops == 0) first_pix = o_pixel;
                pops++;
            end
        end
    endtask

    // One clock: sample mid-cycle, then drive just after the rising edge.
    task automatic tick();
        @(negedge clk);
        monitor_sample();
        @(posedge clk);
        #1;
        if (rand_ready) begin
            i_ready = ($urandom_range(0, 1) == 1) || par;
            par = ~par;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fill_seq();
        logic [7:0] b;
        b = 8'h12;
        for (int k = 0; k < 64; k++) begin
            fb[k] = b;
            b = b + 8'h22;
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 64; k++) fb[k] = 8'($urandom_range(0, 255));
    endtask

    // Reference model: whole pixels per line, first byte is MSB unless swapped.
    task automatic model_frame(output logic keep, output logic ferr);
        int k, npix, mask;
        logic [17:0] e;
        mask = (1 << cfg_dec) - 1;
        keep = ((m_frame_idx & mask) == 0);
        m_frame_idx++;
        ferr = (n_lines != V_ACTIVE);
        if (keep) begin
            k = 0;
            for (int l = 0; l < n_lines; l++) begin
                npix = line_len[l] / BPP;
                if (npix > H_ACTIVE) npix = H_ACTIVE;
                if (l < V_ACTIVE) begin
                    for (int p = 0; p < npix; p++) begin
                        e[17] = (l == 0) && (p == 0);
                        e[16] = (p == H_ACTIVE - 1);
                        e[15:0] = cfg_swap ? {fb[k+2*p+1], fb[k+2*p]} : {fb[k+2*p], fb[k+2*p+1]};
                        exp_q.push_back(e);
                    end
                end
                k += line_len[l];
            end
            if (!ferr) m_frame_cnt++;
        end
    endtask

    task automatic drive_frame(input bit gaps);
        logic keep, ferr;
        int k;
        model_frame(keep, ferr);
        got_lerr = 0;
        got_ferr = 1'b0;
        i_decimate = cfg_dec;
        i_swap_bytes = cfg_swap;
        i_vsync = 1'b1;
        ticks(3);
        i_vsync = 1'b0;
        ticks(2);
        k = 0;
        for (int l = 0; l < n_lines; l++) begin
            i_hsync = 1'b1;
            tick();
            for (int b = 0; b < line_len[l]; b++) begin
                if (gaps) ticks($urandom_range(0, 2));
                i_byte_en = 1'b1;
                i_data = fb[k];
                k++;
                tick();
                i_byte_en = 1'b0;
            end
            i_hsync = 1'b0;
            tick();
            check("line_err_pulse", 32'(o_line_err), 32'(keep && (line_len[l] != H_ACTIVE * BPP)));
            if (o_line_err) got_lerr++;
            tick();
            check("line_err_clear", 32'(o_line_err), 32'(0));
            ticks(2);
        end
        i_vsync = 1'b1;
        tick();
        check("frame_err_pulse", 32'(o_frame_err), 32'(keep && ferr));
        got_ferr = o_frame_err;
        check("frame_cnt", 32'(o_frame_cnt), 32'(m_frame_cnt));
        tick();
        check("frame_err_clear", 32'(o_frame_err), 32'(0));
        ticks(2);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        tests++;
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pixels missing expected 0", exp_q.size());
            exp_q.delete();
        end
        tick();
        check("drain_empty", 32'(o_valid), 32'(0));
    endtask

    task automatic do_reset();
        i_byte_en = 1'b0;
        i_hsync = 1'b0;
        i_vsync = 1'b1;
        i_reset_n = 1'b0;
        ticks(2);
        i_reset_n = 1'b1;
        exp_q.delete();
        m_frame_idx = 0;
        m_frame_cnt = 0;
        tick();
    endtask

    task automatic set_lines(input int n, input int a, input int b, input int c);
        n_lines = n;
        line_len[0] = a;
        line_len[1] = b;
        line_len[2] = c;
        line_len[3] = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pixel"}, 32'(o_pixel), 32'(0));
        check({tag, "_sof"}, 32'(o_sof), 32'(0));
        check({tag, "_eol"}, 32'(o_eol), 32'(0));
        check({tag, "_valid"}, 32'(o_valid), 32'(0));
        check({tag, "_line_err"}, 32'(o_line_err), 32'(0));
        check({tag, "_frame_err"}, 32'(o_frame_err), 32'(0));
        check({tag, "_overflow"}, 32'(o_overflow), 32'(0));
        check({tag, "_frame_cnt"}, 32'(o_frame_cnt), 32'(0));
        check({tag, "_state"}, 32'(o_state), 32'(IDLE));
    endtask

    initial begin
        logic [17:0] held;
        int r;
        tests = 0; fails = 0; pops = 0; first_pix = '0;
        m_frame_idx = 0; m_frame_cnt = 0;
        rand_ready = 1'b0; par = 1'b0;
        cfg_swap = 1'b0; cfg_dec = 2'd0;
        i_reset_n = 1'b0; i_byte_en = 1'b0; i_data = '0; i_hsync = 1'b0;
        i_vsync = 1'b1; i_enable = 1'b1; i_decimate = '0; i_swap_bytes = 1'b0;
        i_clear_status = 1'b0; i_ready = 1'b1;

        vecs[0] = '{"nominal",  1'b0, 2, 8,  8, 0, 8, 0, 1'b0, 16'h1234};
        vecs[1] = '{"swap",     1'b1, 2, 8,  8, 0, 8, 0, 1'b0, 16'h3412};
        vecs[2] = '{"short",    1'b0, 2, 6,  8, 0, 7, 1, 1'b0, 16'h1234};
        vecs[3] = '{"long",     1'b0, 2, 10, 8, 0, 8, 1, 1'b0, 16'h1234};
        vecs[4] = '{"3lines",   1'b0, 3, 8,  8, 8, 8, 0, 1'b1, 16'h1234};
        vecs[5] = '{"1line",    1'b0, 1, 8,  0, 0, 4, 0, 1'b1, 16'h1234};
        vecs[6] = '{"oddbytes", 1'b0, 2, 7,  8, 0, 7, 1, 1'b0, 16'h1234};

        // Reset state.
        ticks(2);
        check_all_zero("reset");
        i_reset_n = 1'b1;
        tick();

        // Table-driven whole-frame scenarios.
        for (int i = 0; i < 7; i++) begin
            cfg_swap = vecs[i].swap;
            cfg_dec = 2'd0;
            set_lines(vecs[i].nlines, vecs[i].len0, vecs[i].len1, vecs[i].len2);
            fill_seq();
            pops = 0;
            first_pix = '0;
            drive_frame(1'b0);
            drain();
            check({vecs[i].name, "_pixels"}, 32'(pops), 32'(vecs[i].exp_pix));
            check({vecs[i].name, "_first"}, 32'(first_pix), 32'(vecs[i].exp_first));
            check({vecs[i].name, "_line_errs"}, 32'(got_lerr), 32'(vecs[i].exp_lerr));
            check({vecs[i].name, "_frame_err"}, 32'(got_ferr), 32'(vecs[i].exp_ferr));
        end

        // Stalled consumer: FIFO keeps the first 4 pixels, the rest overflow.
        cfg_swap = 1'b0;
        set_lines(2, 8, 8, 0);
        fill_seq();
        i_ready = 1'b0;
        pops = 0;
        drive_frame(1'b0);
        while (exp_q.size() > FIFO_DEPTH) void'(exp_q.pop_back());
        held = exp_q[0];
        check("ovf_set", 32'(o_overflow), 32'(1));
        check("ovf_valid", 32'(o_valid), 32'(1));
        check("ovf_head", 32'({o_sof, o_eol, o_pixel}), 32'(held));
        ticks(3);
        check("ovf_head_stable", 32'({o_sof, o_eol, o_pixel}), 32'(held));
        check("ovf_sticky", 32'(o_overflow), 32'(1));
        i_clear_status = 1'b1;
        tick();
        i_clear_status = 1'b0;
        check("ovf_cleared", 32'(o_overflow), 32'(0));
        i_ready = 1'b1;
        drain();
        check("ovf_held_pixels", 32'(pops), 32'(FIFO_DEPTH));

        // Decimation by 2 over four frames: frames 0 and 2 survive.
        do_reset();
        cfg_dec = 2'd1;
        pops = 0;
        for (int f = 0; f < 4; f++) begin
            set_lines(2, 8, 8, 0);
            fill_seq();
            drive_frame(1'b0);
            drain();
        end
        check("dec_pixels", 32'(pops), 32'(16));
        check("dec_frame_cnt", 32'(o_frame_cnt), 32'(2));

        // Reset in the middle of a line, then a clean frame.
        cfg_dec = 2'd0;
        i_decimate = 2'd0;
        i_ready = 1'b0;
        fill_seq();
        i_vsync = 1'b1;
        ticks(3);
        i_vsync = 1'b0;
        ticks(2);
        i_hsync = 1'b1;
        tick();
        for (int b = 0; b < 3; b++) begin
            i_byte_en = 1'b1;
            i_data = fb[b];
            tick();
        end
        check("midreset_pre_valid", 32'(o_valid), 32'(1));
        #2;
        i_reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        i_byte_en = 1'b0;
        i_hsync = 1'b0;
        i_vsync = 1'b1;
        ticks(2);
        i_reset_n = 1'b1;
        exp_q.delete();
        m_frame_idx = 0;
        m_frame_cnt = 0;
        i_ready = 1'b1;
        tick();
        set_lines(2, 8, 8, 0);
        pops = 0;
        first_pix = '0;
        drive_frame(1'b0);
        drain();
        check("postreset_pixels", 32'(pops), 32'(8));
        check("postreset_first", 32'(first_pix), 32'(16'h1234));
        check("postreset_frame_cnt", 32'(o_frame_cnt), 32'(1));

        // Randomized frames: data, gaps, lengths, swap, decimation, ready.
        rand_ready = 1'b1;
        for (int f = 0; f < 8; f++) begin
            int lens[6];
            lens = '{8, 8, 8, 6, 7, 10};
            cfg_swap = ($urandom_range(0, 1) == 1);
            cfg_dec = 2'($urandom_range(0, 2));
            r = $urandom_range(0, 5);
            n_lines = (r < 4) ? 2 : ((r == 4) ? 1 : 3);
            for (int l = 0; l < 4; l++) line_len[l] = lens[$urandom_range(0, 5)];
            fill_rand();
            drive_frame(1'b1);
            drain();
        end
        rand_ready = 1'b0;
        i_ready = 1'b1;
        check("rand_no_overflow", 32'(o_overflow), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
